vending_machine_multi: RTL and testbench

VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

---
 rtl/vending_machine_multi.sv | 182 ++++++++++++++++++
 tb/tb_vending_machine_multi.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product coin vending controller with credit
// accumulation, greedy change payout, cancel/refund and idle auto-refund.
module vending_machine_multi #(
   parameter int N_ITEMS     = 4,
   parameter int CREDIT_W    = 8,
   parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd50, 8'd35, 8'd20, 8'd15},
   parameter int COIN1_VAL   = 5,
   parameter int COIN2_VAL   = 10,
   parameter int COIN3_VAL   = 25,
   parameter int MAX_CREDIT  = 100,
   parameter int TIMEOUT_CYC = 1024,
   localparam int SEL_W      = $clog2(N_ITEMS)
) (
   input  logic                Clk,
   input  logic                rst_n,
   input  logic [1:0]          coin,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel_item,
   input  logic                cancel,
   output logic                vend_valid,
   output logic [SEL_W-1:0]    vend_item,
   output logic [1:0]          change_coin,
   output logic                coin_reject,
   output logic                sel_denied,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CREDIT_W-1:0] C1 = CREDIT_W'(COIN1_VAL);
   localparam logic [CREDIT_W-1:0] C2 = CREDIT_W'(COIN2_VAL);
   localparam logic [CREDIT_W-1:0] C3 = CREDIT_W'(COIN3_VAL);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } state_t;

   state_t              r_state, w_state_n;
   logic [CREDIT_W-1:0] r_credit, w_credit_n;
   logic [CNT_W-1:0]    r_idle_cnt, w_idle_cnt_n;
   logic                r_vend_valid, w_vend_valid_n;
   logic [SEL_W-1:0]    r_vend_item, w_vend_item_n;
   logic [1:0]          r_change_coin, w_change_coin_n;
   logic                r_coin_reject, w_coin_reject_n;
   logic                r_sel_denied, w_sel_denied_n;
   logic                r_busy, w_busy_n;

   logic [CREDIT_W-1:0] w_coin_v, w_price, w_base, w_chg_v;
   logic [CREDIT_W:0]   w_sum;
   logic                w_coin_fit, w_sel_ok, w_active;
   logic [1:0]          w_chg_code;

   function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
      case (c)
         2'b01:   coin_value = C1;
         2'b10:   coin_value = C2;
         2'b11:   coin_value = C3;
         default: coin_value = {CREDIT_W{1'b0}};
      endcase
   endfunction

   // Coin decode, ceiling check, price lookup and largest-coin-that-fits selection
   always_comb begin
      w_coin_v   = coin_value(coin);
      w_sum      = {1'b0, r_credit} + {1'b0, w_coin_v};
      w_coin_fit = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
      w_base     = ((coin != 2'b00) && w_coin_fit) ? w_sum[CREDIT_W-1:0] : r_credit;
      w_active   = (coin != 2'b00) || sel_valid || cancel;
      w_sel_ok   = (32'(sel_item) < 32'(N_ITEMS));
      w_price    = w_sel_ok ? PRICES[32'(sel_item)*CREDIT_W +: CREDIT_W] : {CREDIT_W{1'b1}};
      if (r_credit >= C3) begin
         w_chg_code = 2'b11;
         w_chg_v    = C3;
      end else if (r_credit >= C2) begin
         w_chg_code = 2'b10;
         w_chg_v    = C2;
      end else if (r_credit >= C1) begin
         w_chg_code = 2'b01;
         w_chg_v    = C1;
      end else begin
         w_chg_code = 2'b00;
         w_chg_v    = {CREDIT_W{1'b0}};
      end
   end

   // Next-state, credit bookkeeping and next output values
   always_comb begin
      w_state_n       = r_state;
      w_credit_n      = r_credit;
      w_idle_cnt_n    = {CNT_W{1'b0}};
      w_vend_valid_n  = 1'b0;
      w_vend_item_n   = {SEL_W{1'b0}};
      w_change_coin_n = 2'b00;
      w_coin_reject_n = 1'b0;
      w_sel_denied_n  = 1'b0;
      case (r_state)
         ST_IDLE, ST_CREDIT: begin
            // a coin is credited even when a selection or cancel arrives with it
            w_coin_reject_n = (coin != 2'b00) && !w_coin_fit;
            w_credit_n      = w_base;
            w_state_n       = (w_base != {CREDIT_W{1'b0}}) ? ST_CREDIT : ST_IDLE;
            if (cancel && (r_state == ST_CREDIT)) begin
               w_state_n = ST_CHANGE;
            end else if (sel_valid && !cancel) begin
               // affordability judged on credit before this edge
               if (w_sel_ok && (r_credit >= w_price)) begin
                  w_credit_n     = w_base - w_price;
                  w_state_n      = ST_VEND;
                  w_vend_valid_n = 1'b1;
                  w_vend_item_n  = sel_item;
               end else begin
                  w_sel_denied_n = 1'b1;
               end
            end else if (!w_active && (r_state == ST_CREDIT)) begin
               if (r_idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  w_state_n = ST_CHANGE;
               end else begin
                  w_idle_cnt_n = r_idle_cnt + CNT_W'(1);
               end
            end else begin
               w_idle_cnt_n = {CNT_W{1'b0}};
            end
         end
         ST_VEND: begin
            w_coin_reject_n = (coin != 2'b00);
            w_state_n       = (r_credit != {CREDIT_W{1'b0}}) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            w_coin_reject_n = (coin != 2'b00);
            if (r_credit == {CREDIT_W{1'b0}}) begin
               w_state_n = ST_IDLE;
            end else begin
               w_change_coin_n = w_chg_code;
               w_credit_n      = r_credit - w_chg_v;
               w_state_n       = ((r_credit - w_chg_v) == {CREDIT_W{1'b0}}) ? ST_IDLE : ST_CHANGE;
            end
         end
         default: begin
            w_state_n  = ST_IDLE;
            w_credit_n = {CREDIT_W{1'b0}};
         end
      endcase
      w_busy_n = (w_state_n == ST_VEND) || (w_state_n == ST_CHANGE);
   end

   // State, credit, timeout counter and output registers; reset abandons any payout
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_credit      <= {CREDIT_W{1'b0}};
         r_idle_cnt    <= {CNT_W{1'b0}};
         r_vend_valid  <= 1'b0;
         r_vend_item   <= {SEL_W{1'b0}};
         r_change_coin <= 2'b00;
         r_coin_reject <= 1'b0;
         r_sel_denied  <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_credit      <= w_credit_n;
         r_idle_cnt    <= w_idle_cnt_n;
         r_vend_valid  <= w_vend_valid_n;
         r_vend_item   <= w_vend_item_n;
         r_change_coin <= w_change_coin_n;
         r_coin_reject <= w_coin_reject_n;
         r_sel_denied  <= w_sel_denied_n;
         r_busy        <= w_busy_n;
      end
   end

   assign vend_valid  = r_vend_valid;
   assign vend_item   = r_vend_item;
   assign change_coin = r_change_coin;
   assign coin_reject = r_coin_reject;
   assign sel_denied  = r_sel_denied;
   assign credit      = r_credit;
   assign busy        = r_busy;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model (credit total plus a
// scripted queue of per-cycle payout outputs computed by greedy arithmetic).
module tb_vending_machine_multi;

   localparam int T_OUT = 16;
   localparam int MAXC  = 100;

   logic       Clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] coin = 2'b00;
   logic       sel_valid = 1'b0;
   logic [1:0] sel_item = 2'b00;
   logic       cancel = 1'b0;
   logic       vend_valid;
   logic [1:0] vend_item;
   logic [1:0] change_coin;
   logic       coin_reject;
   logic       sel_denied;
   logic [7:0] credit;
   logic       busy;

   int total = 0;
   int bad   = 0;

   vending_machine_multi #(.TIMEOUT_CYC(T_OUT)) dut (
      .Clk(Clk), .rst_n(rst_n), .coin(coin), .sel_valid(sel_valid),
      .sel_item(sel_item), .cancel(cancel), .vend_valid(vend_valid),
      .vend_item(vend_item), .change_coin(change_coin), .coin_reject(coin_reject),
      .sel_denied(sel_denied), .credit(credit), .busy(busy)
   );

   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   typedef struct { logic v; int item; int chg; int cr; logic bz; } rec_t;
   rec_t q[$];
   int   prices[4] = '{15, 20, 35, 50};
   int   m_credit = 0;
   int   m_idle   = 0;
   logic e_vend = 1'b0, e_rej = 1'b0, e_den = 1'b0, e_busy = 1'b0;
   int   e_item = 0, e_chg = 0;

   function automatic int cval(input int c);
      case (c)
         1: return 5;
         2: return 10;
         3: return 25;
         default: return 0;
      endcase
   endfunction

   function automatic int ccode(input int v);
      case (v)
         5:  return 1;
         10: return 2;
         25: return 3;
         default: return 0;
      endcase
   endfunction

   task automatic push_rec(input logic v, input int item, input int chg, input int cr, input logic bz);
      rec_t r;
      r.v = v; r.item = item; r.chg = chg; r.cr = cr; r.bz = bz;
      q.push_back(r);
   endtask

   // Script the busy period: optional vend pulse, then greedy coins one per cycle
   task automatic payout(input int amt, input logic is_vend, input int item);
      int rem;
      int v;
      rem = amt;
      push_rec(is_vend, is_vend ? item : 0, 0, rem, 1'b1);
      if (is_vend) push_rec(1'b0, 0, 0, rem, rem > 0);
      while (rem > 0) begin
         v = (rem >= 25) ? 25 : ((rem >= 10) ? 10 : 5);
         rem -= v;
         push_rec(1'b0, 0, ccode(v), rem, rem > 0);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_credit = 0; m_idle = 0;
      e_vend = 1'b0; e_rej = 1'b0; e_den = 1'b0; e_busy = 1'b0;
      e_item = 0; e_chg = 0;
   endtask

   task automatic model_cycle(input int c, input logic s, input int it, input logic cn);
      int   base;
      logic act;
      rec_t r;
      e_vend = 1'b0; e_item = 0; e_chg = 0; e_rej = 1'b0; e_den = 1'b0;
      if (q.size() > 0) begin
         r = q.pop_front();
         e_rej = (c != 0);
         m_idle = 0;
         e_vend = r.v; e_item = r.item; e_chg = r.chg; m_credit = r.cr; e_busy = r.bz;
      end else begin
         e_busy = 1'b0;
         base = m_credit;
         if (c != 0) begin
            if (base + cval(c) <= MAXC) base += cval(c);
            else e_rej = 1'b1;
         end
         act = (c != 0) || s || cn;
         if (act || m_credit == 0) m_idle = 0;
         else m_idle++;
         if (cn) begin
            if (m_credit > 0) payout(base, 1'b0, 0);
         end else if (s) begin
            if (m_credit >= prices[it]) payout(base - prices[it], 1'b1, it);
            else e_den = 1'b1;
         end else if (m_idle == T_OUT) begin
            m_idle = 0;
            payout(m_credit, 1'b0, 0);
         end
         if (q.size() > 0) begin
            r = q.pop_front();
            e_vend = r.v; e_item = r.item; e_chg = r.chg; m_credit = r.cr; e_busy = r.bz;
         end else begin
            m_credit = base;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string pfx);
      chk({pfx, ".vend_valid"},  32'(vend_valid),  32'(e_vend));
      chk({pfx, ".vend_item"},   32'(vend_item),   32'(e_item));
      chk({pfx, ".change_coin"}, 32'(change_coin), 32'(e_chg));
      chk({pfx, ".coin_reject"}, 32'(coin_reject), 32'(e_rej));
      chk({pfx, ".sel_denied"},  32'(sel_denied),  32'(e_den));
      chk({pfx, ".credit"},      32'(credit),      32'(m_credit));
      chk({pfx, ".busy"},        32'(busy),        32'(e_busy));
   endtask

   task automatic step(input logic [1:0] c, input logic s, input logic [1:0] it, input logic cn);
      coin = c; sel_valid = s; sel_item = it; cancel = cn;
      model_cycle(int'(c), s, int'(it), cn);
      @(posedge Clk);
      #1;
      check_all("cyc");
      coin = 2'b00; sel_valid = 1'b0; cancel = 1'b0;
   endtask

   task automatic idle_step();
      step(2'b00, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && q.size() > 0; k++) idle_step();
   endtask

   task automatic to_idle();
      drain();
      if (m_credit > 0) step(2'b00, 1'b0, 2'b00, 1'b1);
      drain();
   endtask

   // Assert reset between edges, check outputs drop immediately, release at negedge
   task automatic reset_mid(input string pfx);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all({pfx, ".async"});
      @(posedge Clk);
      #1;
      check_all({pfx, ".held"});
      @(negedge Clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int lvl, pc;
      logic [1:0] rc, ri;
      logic rs, rcn;

      // reset state
      model_reset();
      #1;
      check_all("rst0");
      @(posedge Clk); #1;
      check_all("rst1");
      @(negedge Clk);
      rst_n = 1'b1;

      // 10 + 10, buy item 0 (15): vend, then a single 5 coin back
      step(2'b10, 1'b0, 2'b00, 1'b0);
      chk("d33.credit10", 32'(credit), 32'd10);
      step(2'b10, 1'b0, 2'b00, 1'b0);
      step(2'b00, 1'b1, 2'b00, 1'b0);
      chk("d33.vend", 32'(vend_valid), 32'd1);
      chk("d33.item", 32'(vend_item), 32'd0);
      chk("d33.credit5", 32'(credit), 32'd5);
      idle_step();
      chk("d33.gap", 32'(change_coin), 32'd0);
      idle_step();
      chk("d33.chg5", 32'(change_coin), 32'd1);
      chk("d33.credit0", 32'(credit), 32'd0);
      chk("d33.idle", 32'(busy), 32'd0);

      // 75, buy item 2 (35): change 25, 10, 5 on consecutive cycles
      to_idle();
      repeat (3) step(2'b11, 1'b0, 2'b00, 1'b0);
      step(2'b00, 1'b1, 2'b10, 1'b0);
      chk("d34.vend", 32'(vend_valid), 32'd1);
      chk("d34.item", 32'(vend_item), 32'd2);
      chk("d34.credit40", 32'(credit), 32'd40);
      idle_step();
      idle_step();
      chk("d34.chg25", 32'(change_coin), 32'd3);
      idle_step();
      chk("d34.chg10", 32'(change_coin), 32'd2);
      idle_step();
      chk("d34.chg5", 32'(change_coin), 32'd1);
      chk("d34.credit0", 32'(credit), 32'd0);

      // ceiling: 100 then coin 5 rejected; credit 10 cannot buy item 1
      to_idle();
      repeat (4) step(2'b11, 1'b0, 2'b00, 1'b0);
      step(2'b01, 1'b0, 2'b00, 1'b0);
      chk("d35.reject", 32'(coin_reject), 32'd1);
      chk("d35.credit100", 32'(credit), 32'd100);
      idle_step();
      chk("d35.reject_pulse", 32'(coin_reject), 32'd0);
      to_idle();
      step(2'b10, 1'b0, 2'b00, 1'b0);
      step(2'b00, 1'b1, 2'b01, 1'b0);
      chk("d35.denied", 32'(sel_denied), 32'd1);
      chk("d35.credit10", 32'(credit), 32'd10);
      chk("d35.novend", 32'(vend_valid), 32'd0);

      // cancel beats select at credit 30: refund 25 then 5
      to_idle();
      step(2'b11, 1'b0, 2'b00, 1'b0);
      step(2'b01, 1'b0, 2'b00, 1'b0);
      step(2'b00, 1'b1, 2'b00, 1'b1);
      chk("d36.novend", 32'(vend_valid), 32'd0);
      chk("d36.nodeny", 32'(sel_denied), 32'd0);
      chk("d36.busy", 32'(busy), 32'd1);
      idle_step();
      chk("d36.chg25", 32'(change_coin), 32'd3);
      idle_step();
      chk("d36.chg5", 32'(change_coin), 32'd1);
      chk("d36.credit0", 32'(credit), 32'd0);

      // idle timeout: coin 10 then 16 quiet cycles refunds 10
      to_idle();
      step(2'b10, 1'b0, 2'b00, 1'b0);
      repeat (T_OUT - 1) idle_step();
      chk("d36.to_wait", 32'(busy), 32'd0);
      idle_step();
      chk("d36.to_fire", 32'(busy), 32'd1);
      idle_step();
      chk("d36.to_chg10", 32'(change_coin), 32'd2);
      chk("d36.to_credit0", 32'(credit), 32'd0);

      // reset mid-payout, then a coin 5 is credited normally
      to_idle();
      step(2'b11, 1'b0, 2'b00, 1'b0);
      step(2'b11, 1'b0, 2'b00, 1'b0);
      step(2'b00, 1'b0, 2'b00, 1'b1);
      idle_step();
      chk("d37.chg25", 32'(change_coin), 32'd3);
      reset_mid("d37");
      chk("d37.credit0", 32'(credit), 32'd0);
      step(2'b01, 1'b0, 2'b00, 1'b0);
      chk("d37.credit5", 32'(credit), 32'd5);

      // randomized traffic in bursts of varying activity
      for (int blk = 0; blk < 80; blk++) begin
         lvl = int'($urandom_range(0, 2));
         pc  = (lvl == 0) ? 50 : ((lvl == 1) ? 10 : 0);
         for (int n = 0; n < 40; n++) begin
            rc  = (int'($urandom_range(0, 99)) < pc) ? 2'($urandom_range(1, 3)) : 2'b00;
            rs  = (int'($urandom_range(0, 99)) < pc);
            rcn = (int'($urandom_range(0, 399)) < pc);
            ri  = 2'($urandom_range(0, 3));
            step(rc, rs, ri, rcn);
            if ($urandom_range(0, 499) == 0) reset_mid("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
